// File: rtl/vga_fb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : vga_fb
// Description : 640x400 VGA timing generator scanning an internal RGB332
//               framebuffer that is filled through a byte-wide CPU write port.
// Revision    : 1.0
//------------------------------------------------------------------------------
module vga_fb #(
  parameter int H           = 640,
  parameter int HFP         = 16,
  parameter int HS          = 96,
  parameter int HBP         = 48,
  parameter int V           = 400,
  parameter int VFP         = 12,
  parameter int VS          = 2,
  parameter int VBP         = 35,
  parameter int PIXEL_COUNT = 256000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        hs,
  output logic        vs,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        VGA_HB,
  output logic        VGA_VB,
  output logic        VGA_DE
);

  localparam int c_H_TOTAL = H + HFP + HS + HBP;
  localparam int c_V_TOTAL = V + VFP + VS + VBP;
  localparam int c_AW      = $clog2(PIXEL_COUNT);

  logic [9:0]      r_h_cnt;
  logic [9:0]      r_v_cnt;
  logic [7:0]      r_mem [PIXEL_COUNT];

  logic            w_hb0;
  logic            w_vb0;
  logic            w_hs0;
  logic            w_vs0;
  logic [c_AW-1:0] w_rd_addr;

  logic [7:0]      r_pix1;
  logic            r_hs1, r_vs1, r_hb1, r_vb1;
  logic            r_hs2, r_vs2, r_hb2, r_vb2, r_de2;
  logic [7:0]      r_r2, r_g2, r_b2;

  // The frame counter steps at the start of hsync, not at the end of the line.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      if (r_h_cnt == 10'(c_H_TOTAL - 1))
        r_h_cnt <= '0;
      else
        r_h_cnt <= r_h_cnt + 10'd1;
      if (r_h_cnt == 10'(H + HFP)) begin
        if (r_v_cnt == 10'(c_V_TOTAL - 1))
          r_v_cnt <= '0;
        else
          r_v_cnt <= r_v_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    w_hb0     = (r_h_cnt >= 10'(H));
    w_vb0     = (r_v_cnt >= 10'(V));
    w_hs0     = !((r_h_cnt >= 10'(H + HFP)) && (r_h_cnt < 10'(H + HFP + HS)));
    w_vs0     = !((r_v_cnt >= 10'(V + VFP)) && (r_v_cnt < 10'(V + VFP + VS)));
    w_rd_addr = '0;
    if (!w_hb0 && !w_vb0)
      w_rd_addr = c_AW'(r_v_cnt) * c_AW'(H) + c_AW'(r_h_cnt);
  end

  // Full 32-bit range check so high address bits can never alias into the RAM.
  always_ff @(posedge pclk) begin
    if (!reset && cpu_wr && (cpu_addr < 32'(PIXEL_COUNT)))
      r_mem[cpu_addr[c_AW-1:0]] <= cpu_data;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_pix1 <= '0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_hb1  <= 1'b1;
      r_vb1  <= 1'b1;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_hb2  <= 1'b1;
      r_vb2  <= 1'b1;
      r_de2  <= 1'b0;
      r_r2   <= '0;
      r_g2   <= '0;
      r_b2   <= '0;
    end else begin
      r_pix1 <= r_mem[w_rd_addr];
      r_hs1  <= w_hs0;
      r_vs1  <= w_vs0;
      r_hb1  <= w_hb0;
      r_vb1  <= w_vb0;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_hb2  <= r_hb1;
      r_vb2  <= r_vb1;
      r_de2  <= !(r_hb1 || r_vb1);
      if (!(r_hb1 || r_vb1)) begin
        r_r2 <= {r_pix1[7:5], r_pix1[7:5], r_pix1[7:6]};
        r_g2 <= {r_pix1[4:2], r_pix1[4:2], r_pix1[4:3]};
        r_b2 <= {r_pix1[1:0], r_pix1[1:0], r_pix1[1:0], r_pix1[1:0]};
      end else begin
        r_r2 <= '0;
        r_g2 <= '0;
        r_b2 <= '0;
      end
    end
  end

  assign hs     = r_hs2;
  assign vs     = r_vs2;
  assign VGA_HB = r_hb2;
  assign VGA_VB = r_vb2;
  assign VGA_DE = r_de2;
  assign r      = r_r2;
  assign g      = r_g2;
  assign b      = r_b2;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_vga_fb
// Description : Directed bench for vga_fb: full-size instance for pixel data and
//               line timing, a tiny-geometry instance for frame timing.
// Revision    : 1.0
//------------------------------------------------------------------------------
module tb_vga_fb;

  logic        pclk = 1'b0;
  logic        reset;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_data;

  logic        hs, vs, hb, vb, de;
  logic [7:0]  r, g, b;
  logic        s_hs, s_vs, s_hb, s_vb, s_de;
  logic [7:0]  s_r, s_g, s_b;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  vga_fb u_dut (
    .pclk(pclk), .reset(reset), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .VGA_HB(hb), .VGA_VB(vb), .VGA_DE(de)
  );

  // 15 clocks per line, 8 lines per frame: a whole frame is only 120 cycles.
  vga_fb #(
    .H(8), .HFP(2), .HS(3), .HBP(2), .V(4), .VFP(1), .VS(2), .VBP(1), .PIXEL_COUNT(32)
  ) u_small (
    .pclk(pclk), .reset(reset), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .hs(s_hs), .vs(s_vs), .r(s_r), .g(s_g), .b(s_b), .VGA_HB(s_hb), .VGA_VB(s_vb), .VGA_DE(s_de)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check_val({tag, "_big"},   {3'b0, hs, vs, hb, vb, de, r, g, b},           {3'b0, 5'b11110, 24'h0});
    check_val({tag, "_small"}, {3'b0, s_hs, s_vs, s_hb, s_vb, s_de, s_r, s_g, s_b}, {3'b0, 5'b11110, 24'h0});
  endtask

  task automatic check_px(input string tag, input logic exp_de, input logic [23:0] exp_rgb);
    check_val({tag, "_de"},  {31'b0, de},   {31'b0, exp_de});
    check_val({tag, "_rgb"}, {8'b0, r, g, b}, {8'b0, exp_rgb});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa [14];
    logic [7:0]  wd [14];
    int big_de, big_hs, big_hb, big_vb, big_vs, big_leak;
    int sm_de, sm_hs, sm_hb, sm_vb, sm_vs, sm_leak;
    int hs_fall, hs_rise, svb_rise, svs_fall1, svs_fall2;
    logic p_hs, p_svs, p_svb;

    big_de = 0; big_hs = 0; big_hb = 0; big_vb = 0; big_vs = 0; big_leak = 0;
    sm_de = 0; sm_hs = 0; sm_hb = 0; sm_vb = 0; sm_vs = 0; sm_leak = 0;
    hs_fall = -1; hs_rise = -1; svb_rise = -1; svs_fall1 = -1; svs_fall2 = -1;
    p_hs = 1'b1; p_svs = 1'b1; p_svb = 1'b1;

    reset = 1'b1; cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
    repeat (3) @(negedge pclk);
    check_rst("rst_hold");
    reset = 1'b0;

    // Real pixels first, then out-of-range addresses whose low bits alias pixels 0 and 3.
    wa = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd10, 32'd20, 32'd30, 32'd639, 32'd640,
           32'd255999, 32'd256000, 32'hFFFF_FFFF, 32'h0004_0000, 32'h0004_0003};
    wd = '{8'hE0, 8'h1C, 8'h03, 8'hA5, 8'hE0, 8'hE0, 8'hE0, 8'hFF, 8'h1C,
           8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 14; i++) begin
      cpu_wr = 1'b1; cpu_addr = wa[i]; cpu_data = wd[i];
      @(negedge pclk);
    end
    cpu_wr = 1'b0;

    // Restart the frame; the write issued under reset must be dropped.
    reset = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'd10; cpu_data = 8'h1C;
    repeat (2) @(negedge pclk);
    cpu_wr = 1'b0; reset = 1'b0;

    // At negedge n the counter sits at t = n; outputs show the pixel of t = n-2.
    for (int n = 0; n <= 1100; n++) begin
      if (n >= 2 && n < 802) begin
        if (de) big_de++;
        if (!hs) big_hs++;
        if (hb) big_hb++;
        if (vb) big_vb++;
        if (!vs) big_vs++;
        if (!de && {r, g, b} != 24'h0) big_leak++;
        if (p_hs && !hs && hs_fall < 0) hs_fall = n;
        if (!p_hs && hs && hs_fall >= 0 && hs_rise < 0) hs_rise = n;
      end
      if (n >= 2 && n < 122) begin
        if (s_de) sm_de++;
        if (!s_hs) sm_hs++;
        if (s_hb) sm_hb++;
        if (s_vb) sm_vb++;
        if (!s_vs) sm_vs++;
        if (!s_de && {s_r, s_g, s_b} != 24'h0) sm_leak++;
      end
      if (n >= 2) begin
        if (!p_svb && s_vb && svb_rise < 0) svb_rise = n;
        if (p_svs && !s_vs) begin
          if (svs_fall1 < 0) svs_fall1 = n;
          else if (svs_fall2 < 0) svs_fall2 = n;
        end
      end
      p_hs = hs; p_svs = s_vs; p_svb = s_vb;

      case (n)
        0:   check_rst("scan_n0");
        1:   check_val("scan_n1_de", {31'b0, de}, 32'd0);
        2: begin
          check_px("px_0_0", 1'b1, 24'hFF0000);
          check_val("small_px0", {7'b0, s_de, s_r, s_g, s_b}, {7'b0, 1'b1, 24'hFF0000});
        end
        3:   check_px("px_1_0", 1'b1, 24'h00FF00);
        4:   check_px("px_2_0", 1'b1, 24'h0000FF);
        5:   check_px("px_3_0", 1'b1, 24'hB62455);
        12:  check_px("px_10_rst_wr", 1'b1, 24'hFF0000);
        22:  check_px("px_20_wr_ahead", 1'b1, 24'h0000FF);
        32:  check_px("px_30_read_first", 1'b1, 24'hFF0000);
        122: check_val("small_wrap_de", {31'b0, s_de}, 32'd1);
        641: check_px("px_639_0", 1'b1, 24'hFFFFFF);
        642: begin
          check_px("px_640_blank", 1'b0, 24'h000000);
          check_val("px_640_hb", {31'b0, hb}, 32'd1);
        end
        802: begin
          check_px("px_0_1", 1'b1, 24'h00FF00);
          check_val("px_0_1_hb", {31'b0, hb}, 32'd0);
        end
        default: ;
      endcase

      cpu_wr = 1'b0;
      if (n == 19) begin
        cpu_wr = 1'b1; cpu_addr = 32'd20; cpu_data = 8'h03;
      end else if (n == 30) begin
        cpu_wr = 1'b1; cpu_addr = 32'd30; cpu_data = 8'h03;
      end
      if (n == 1100) reset = 1'b1;
      @(negedge pclk);
    end

    // Single-cycle reset in the middle of line 1.
    check_rst("mid_rst");
    reset = 1'b0;
    check_rst("mid_rst_n0");
    @(negedge pclk);
    check_val("mid_rst_n1_de", {31'b0, de}, 32'd0);
    @(negedge pclk);
    check_px("mid_rst_px_0_0", 1'b1, 24'hFF0000);

    check_val("big_de_cnt",   32'(big_de),   32'd640);
    check_val("big_hs_cnt",   32'(big_hs),   32'd96);
    check_val("big_hb_cnt",   32'(big_hb),   32'd160);
    check_val("big_vb_cnt",   32'(big_vb),   32'd0);
    check_val("big_vs_cnt",   32'(big_vs),   32'd0);
    check_val("big_leak",     32'(big_leak), 32'd0);
    check_val("big_hs_fall",  32'(hs_fall),  32'd658);
    check_val("big_hs_rise",  32'(hs_rise),  32'd754);
    check_val("sm_de_cnt",    32'(sm_de),    32'd32);
    check_val("sm_hs_cnt",    32'(sm_hs),    32'd24);
    check_val("sm_hb_cnt",    32'(sm_hb),    32'd56);
    check_val("sm_vb_cnt",    32'(sm_vb),    32'd60);
    check_val("sm_vs_cnt",    32'(sm_vs),    32'd30);
    check_val("sm_leak",      32'(sm_leak),  32'd0);
    check_val("sm_vb_rise",   32'(svb_rise), 32'd58);
    check_val("sm_vs_fall1",  32'(svs_fall1), 32'd73);
    check_val("sm_vs_period", 32'(svs_fall2 - svs_fall1), 32'd120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
